// File: rtl/spi_byte_engine.sv
// Byte-level SPI Mode 0 master shifter: one byte per getByte request, MSB first,
// MISO sampled on each SCLK rise, received byte published on RxData at completion.
module spi_byte_engine #(
    parameter int CLK_DIV    = 1,
    parameter int GAP_CYCLES = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       getByte,
    input  logic [7:0] sndData,
    input  logic       MISO,
    output logic       BUSY,
    output logic [7:0] RxData,
    output logic       SCLK,
    output logic       MOSI
);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       tx_sr_q, tx_sr_d;
    logic [7:0]       rx_sr_q, rx_sr_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             busy_q, busy_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            div_cnt_q <= '0;
            gap_cnt_q <= '0;
            bit_cnt_q <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            rx_data_q <= rx_data_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
        end
    end

    // NOTE: every next-state signal is defaulted first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        gap_cnt_d = gap_cnt_q;
        bit_cnt_d = bit_cnt_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        rx_data_d = rx_data_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;

        case (state_q)
            IDLE: begin
                sclk_d = 1'b0;
                mosi_d = 1'b0;
                busy_d = 1'b0;
                if (getByte) begin
                    tx_sr_d   = sndData;
                    mosi_d    = sndData[7];
                    busy_d    = 1'b1;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end

            SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    sclk_d    = ~sclk_q;
                    if (!sclk_q) begin
                        rx_sr_d = {rx_sr_q[6:0], MISO};
                    end else if (bit_cnt_q != 3'd7) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_sr_d   = {tx_sr_q[6:0], 1'b0};
                        mosi_d    = tx_sr_q[6];
                    end else begin
                        // rx_sr already holds the bit taken on the eighth rise.
                        rx_data_d = rx_sr_q;
                        mosi_d    = 1'b0;
                        gap_cnt_d = '0;
                        if (GAP_CYCLES == 0) begin
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end else begin
                            state_d = GAP;
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end

            GAP: begin
                sclk_d = 1'b0;
                mosi_d = 1'b0;
                busy_d = 1'b1;
                if (gap_cnt_q == GAP_LAST) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign BUSY   = busy_q;
    assign RxData = rx_data_q;
    assign SCLK   = sclk_q;
    assign MOSI   = mosi_q;

endmodule

// File: tb/tb_spi_byte_engine.sv
// Directed bench for spi_byte_engine: two instances (CLK_DIV=1/GAP=1 and
// CLK_DIV=3/GAP=0), each with a Mode 0 slave model and a MOSI capture register.
module tb_spi_byte_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       get1, miso1, busy1, sclk1, mosi1;
    logic [7:0] snd1, rx1;
    logic       get2, miso2, busy2, sclk2, mosi2;
    logic [7:0] snd2, rx2;

    spi_byte_engine #(.CLK_DIV(1), .GAP_CYCLES(1)) dut1 (
        .CLK(clk), .RST(rst), .getByte(get1), .sndData(snd1), .MISO(miso1),
        .BUSY(busy1), .RxData(rx1), .SCLK(sclk1), .MOSI(mosi1)
    );

    spi_byte_engine #(.CLK_DIV(3), .GAP_CYCLES(0)) dut2 (
        .CLK(clk), .RST(rst), .getByte(get2), .sndData(snd2), .MISO(miso2),
        .BUSY(busy2), .RxData(rx2), .SCLK(sclk2), .MOSI(mosi2)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Slave 1: loads its reply when BUSY rises, shifts on each SCLK fall.
    logic [7:0] s1_next = 8'h00;
    logic [7:0] s1_sr   = 8'h00;
    bit         s1_armed = 1'b0;
    assign miso1 = s1_sr[7];
    always @(posedge busy1 or negedge busy1 or negedge sclk1) begin
        if (busy1 !== 1'b1) s1_armed = 1'b0;
        else if (!s1_armed) begin s1_sr = s1_next; s1_armed = 1'b1; end
        else s1_sr = s1_sr << 1;
    end

    logic [7:0] s2_next = 8'h00;
    logic [7:0] s2_sr   = 8'h00;
    bit         s2_armed = 1'b0;
    assign miso2 = s2_sr[7];
    always @(posedge busy2 or negedge busy2 or negedge sclk2) begin
        if (busy2 !== 1'b1) s2_armed = 1'b0;
        else if (!s2_armed) begin s2_sr = s2_next; s2_armed = 1'b1; end
        else s2_sr = s2_sr << 1;
    end

    // MOSI as seen by the slave at each SCLK rise; last eight rises form the byte.
    logic [7:0] cap1 = 8'h00;
    logic [7:0] cap2 = 8'h00;
    int         rises1 = 0;
    int         rises2 = 0;
    time        t2_last = 0;
    time        t2_prev = 0;
    always @(posedge sclk1) begin cap1 = {cap1[6:0], mosi1}; rises1++; end
    always @(posedge sclk2) begin
        cap2 = {cap2[6:0], mosi2}; rises2++;
        t2_prev = t2_last; t2_last = $time;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transfer on dut1, called and returning at a negedge with BUSY low.
    task automatic xfer1(input logic [7:0] tx, input logic [7:0] sl, input bit disturb,
                         output int hi, output logic [7:0] rx);
        int r0;
        s1_next = sl;
        r0 = rises1;
        get1 = 1'b1;
        snd1 = tx;
        @(negedge clk);
        get1 = 1'b0;
        check("busy_rise", busy1, 1'b1);
        hi = 0;
        while (busy1 === 1'b1 && hi < 500) begin
            hi++;
            if (disturb) begin
                get1 = hi[0];
                snd1 = ~snd1;
            end
            @(negedge clk);
        end
        get1 = 1'b0;
        rx = rx1;
        check("rise_count", rises1 - r0, 8);
        check("mosi_bits", cap1, tx);
        check("idle_sclk", sclk1, 1'b0);
        check("idle_mosi", mosi1, 1'b0);
    endtask

    initial begin
        int          hi;
        int          r0;
        int          cnt;
        logic [7:0]  rx;
        logic [39:0] cmd;
        logic [39:0] slv;
        logic [39:0] dout;

        rst = 1'b1;
        get1 = 1'b0; snd1 = 8'h00;
        get2 = 1'b0; snd2 = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_busy1", busy1, 1'b0);
        check("rst_rx1", rx1, 8'h00);
        check("rst_sclk1", sclk1, 1'b0);
        check("rst_mosi1", mosi1, 1'b0);
        check("rst_busy2", busy2, 1'b0);
        check("rst_rx2", rx2, 8'h00);
        check("rst_sclk2", sclk2, 1'b0);
        check("rst_mosi2", mosi2, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Basic byte: A5 out, 3C back, 16 SHIFT cycles + 1 gap cycle.
        xfer1(8'hA5, 8'h3C, 1'b0, hi, rx);
        check("a5_busy_len", hi, 17);
        check("a5_rx", rx, 8'h3C);

        // getByte held high: back-to-back bytes with a one-cycle BUSY-low gap.
        s1_next = 8'hFF;
        get1 = 1'b1;
        snd1 = 8'h01;
        @(negedge clk);
        check("b2b_busy_rise", busy1, 1'b1);
        s1_next = 8'h00;
        snd1 = 8'h80;
        hi = 0;
        while (busy1 === 1'b1 && hi < 500) begin hi++; @(negedge clk); end
        check("b2b_first_len", hi, 17);
        check("b2b_rx_first", rx1, 8'hFF);
        check("b2b_tx_first", cap1, 8'h01);
        @(negedge clk);
        check("b2b_low_gap", busy1, 1'b1);
        get1 = 1'b0;
        hi = 0;
        while (busy1 === 1'b1 && hi < 500) begin hi++; @(negedge clk); end
        check("b2b_second_len", hi, 17);
        check("b2b_rx_second", rx1, 8'h00);
        check("b2b_tx_second", cap1, 8'h80);

        // Five-byte controller sequence.
        cmd  = 40'h8100000000;
        slv  = 40'h1234567890;
        dout = '0;
        for (int i = 0; i < 5; i++) begin
            xfer1(cmd[39-8*i -: 8], slv[39-8*i -: 8], 1'b0, hi, rx);
            dout = {dout[31:0], rx};
            @(negedge clk);
            check("seq_gap_sclk", sclk1, 1'b0);
        end
        check("seq_dout", dout, 40'h1234567890);

        // Reset in mid-byte, after the fourth SCLK rise.
        s1_next = 8'h3C;
        r0 = rises1;
        get1 = 1'b1;
        snd1 = 8'hA5;
        @(negedge clk);
        get1 = 1'b0;
        cnt = 0;
        while (rises1 - r0 < 4 && cnt < 100) begin @(negedge clk); cnt++; end
        check("mid_rise4", rises1 - r0, 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", busy1, 1'b0);
        check("mid_rst_sclk", sclk1, 1'b0);
        check("mid_rst_mosi", mosi1, 1'b0);
        check("mid_rst_rx", rx1, 8'h00);
        @(negedge clk);
        xfer1(8'hC3, 8'h96, 1'b0, hi, rx);
        check("c3_busy_len", hi, 17);
        check("c3_rx", rx, 8'h96);

        // RST and getByte together: reset wins.
        rst = 1'b1;
        get1 = 1'b1;
        snd1 = 8'hFF;
        @(negedge clk);
        rst = 1'b0;
        get1 = 1'b0;
        check("rst_vs_get", busy1, 1'b0);
        @(negedge clk);
        check("rst_vs_get_after", busy1, 1'b0);

        // getByte toggled and sndData changed while busy.
        xfer1(8'h3C, 8'h5A, 1'b1, hi, rx);
        check("dist_busy_len", hi, 17);
        check("dist_rx", rx, 8'h5A);
        r0 = rises1;
        repeat (4) @(negedge clk);
        check("dist_no_restart", busy1, 1'b0);
        check("dist_no_edges", rises1 - r0, 0);

        // CLK_DIV=3, no gap.
        s2_next = 8'hA5;
        r0 = rises2;
        get2 = 1'b1;
        snd2 = 8'h5A;
        @(negedge clk);
        get2 = 1'b0;
        check("div3_busy_rise", busy2, 1'b1);
        hi = 0;
        while (busy2 === 1'b1 && hi < 500) begin hi++; @(negedge clk); end
        check("div3_busy_len", hi, 48);
        check("div3_rx", rx2, 8'hA5);
        check("div3_mosi_bits", cap2, 8'h5A);
        check("div3_rise_count", rises2 - r0, 8);
        check("div3_sclk_period", (t2_last - t2_prev) / 10, 6);
        check("div3_idle_sclk", sclk2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
